// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a registered shared mux output.
// Define MUX_ARBITER_HOLD_EN to let a contended owner keep the mux for up to MAX_HOLD transfers.
module mux_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             grant0,
    output logic             grant1,
    output logic             select,
    output logic [WIDTH-1:0] s,
    output logic             valid
);

    localparam int unsigned CNT_W = 4;

`ifdef MUX_ARBITER_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
`else
    // Without hold support every contended cycle re-arbitrates.
    localparam logic [CNT_W-1:0] HOLD_LIM = '0;
`endif

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_check
        $error("mux_arbiter: MAX_HOLD must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             last_served;
    logic             own_req;
    logic             other_req;
    state_t           other_state;

    // Grants and select come straight from the state register.
    assign grant0 = (state == GRANT0);
    assign grant1 = (state == GRANT1);
    assign select = (state == GRANT1);

    always_comb begin
        own_req     = select ? req1 : req0;
        other_req   = select ? req0 : req1;
        other_state = select ? GRANT0 : GRANT1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s           <= '0;
            valid       <= 1'b0;
            hold_cnt    <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    valid    <= 1'b0;
                    hold_cnt <= '0;
                    // On a tie, the requester that was not served last wins.
                    if (req0 && (!req1 || last_served)) begin
                        state <= GRANT0;
                    end else if (req1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (own_req) begin
                        s     <= select ? data1 : data0;
                        valid <= 1'b1;
                        if (hold_cnt == HOLD_LIM && other_req) begin
                            state       <= other_state;
                            last_served <= select;
                            hold_cnt    <= '0;
                        end else if (hold_cnt != HOLD_LIM) begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end else begin
                        valid       <= 1'b0;
                        last_served <= select;
                        hold_cnt    <= '0;
                        state       <= other_req ? other_state : IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    valid    <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios plus random traffic against a tenure-based model.
// Honours MUX_ARBITER_HOLD_EN the same way as the design.
module tb_mux_arbiter;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned MAX_HOLD = 4;
`ifdef MUX_ARBITER_HOLD_EN
    localparam int LIMIT = MAX_HOLD;
`else
    localparam int LIMIT = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] data0 = '0;
    logic [WIDTH-1:0] data1 = '0;
    logic             grant0;
    logic             grant1;
    logic             select;
    logic [WIDTH-1:0] s;
    logic             valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: current owner (-1 none), transfers in current tenure, last served requester.
    int               m_owner;
    int               m_run;
    int               m_last;
    logic [WIDTH-1:0] m_s;
    logic             m_valid;

    mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .grant0(grant0), .grant1(grant1),
        .select(select), .s(s), .valid(valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        m_s     = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic             r [2];
        logic [WIDTH-1:0] d [2];
        int n, o;
        r[0] = req0; r[1] = req1;
        d[0] = data0; d[1] = data1;
        if (m_owner < 0) begin
            m_valid = 1'b0;
            m_run   = 0;
            if (r[0] && r[1]) m_owner = 1 - m_last;
            else if (r[0])    m_owner = 0;
            else if (r[1])    m_owner = 1;
        end else begin
            n = m_owner;
            o = 1 - n;
            if (r[n]) begin
                m_s     = d[n];
                m_valid = 1'b1;
                m_run   = m_run + 1;
                if (m_run >= LIMIT && r[o]) begin
                    m_owner = o;
                    m_last  = n;
                    m_run   = 0;
                end
            end else begin
                m_valid = 1'b0;
                m_last  = n;
                m_run   = 0;
                m_owner = r[o] ? o : -1;
            end
        end
    endtask

    task automatic step(input string name);
        logic [WIDTH+3:0] exp_v;
        logic [WIDTH+3:0] got_v;
        @(posedge clk);
        model_edge();
        #1;
        exp_v = {(m_owner == 0), (m_owner == 1), (m_owner == 1), m_valid, m_s};
        got_v = {grant0, grant1, select, valid, s};
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got g0=%b g1=%b sel=%b valid=%b s=%h, expected g0=%b g1=%b sel=%b valid=%b s=%h",
                     name, $time, got_v[WIDTH+3], got_v[WIDTH+2], got_v[WIDTH+1], got_v[WIDTH], got_v[WIDTH-1:0],
                     exp_v[WIDTH+3], exp_v[WIDTH+2], exp_v[WIDTH+1], exp_v[WIDTH], exp_v[WIDTH-1:0]);
        end
    endtask

    task automatic go_idle();
        req0 = 1'b0;
        req1 = 1'b0;
        step("go_idle");
        step("go_idle");
    endtask

    task automatic test_reset();
        #12;
        model_reset();
        n_tests++;
        if ({grant0, grant1, select, valid, s} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got g0=%b g1=%b sel=%b valid=%b s=%h, expected all zero",
                     grant0, grant1, select, valid, s);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_contention();
        data0 = 4'b0001;
        data1 = 4'b0010;
        req0  = 1'b1;
        req1  = 1'b1;
        step("contention_first");
        n_tests++;
        if (grant0 !== 1'b1 || grant1 !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_first_tie: got g0=%b g1=%b, expected g0=1 g1=0", grant0, grant1);
        end
        for (int i = 0; i < 24; i++) step("contention");
        go_idle();
    endtask

    task automatic test_single();
        data0 = 4'b1101;
        req0  = 1'b1;
        step("single_grant");
        n_tests++;
        if (grant0 !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant_latency: got g0=%b valid=%b, expected g0=1 valid=0", grant0, valid);
        end
        step("single_data");
        n_tests++;
        if (s !== 4'b1101 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_data_latency: got s=%b valid=%b, expected s=1101 valid=1", s, valid);
        end
        req0 = 1'b0;
        step("single_release");
        n_tests++;
        if (grant0 !== 1'b0 || valid !== 1'b0 || s !== 4'b1101) begin
            n_fail++;
            $display("FAIL single_release: got g0=%b valid=%b s=%b, expected g0=0 valid=0 s=1101",
                     grant0, valid, s);
        end
        go_idle();
    endtask

    task automatic test_handover();
        data0 = 4'b0101;
        data1 = 4'b1010;
        req0  = 1'b1;
        step("handover_g0");
        step("handover_xfer");
        req0 = 1'b0;
        req1 = 1'b1;
        step("handover_switch");
        n_tests++;
        if (grant1 !== 1'b1 || grant0 !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL handover_direct: got g0=%b g1=%b valid=%b, expected g0=0 g1=1 valid=0",
                     grant0, grant1, valid);
        end
        step("handover_g1_xfer");
        go_idle();
    endtask

    task automatic test_hold_saturation();
        req1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data1 = 4'($urandom_range(0, 15));
            step("hold_sat_g1");
        end
        req0 = 1'b1;
        step("hold_sat_switch");
        n_tests++;
        if (grant0 !== 1'b1 || grant1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_sat_switch: got g0=%b g1=%b, expected g0=1 g1=0", grant0, grant1);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        data1 = 4'b0110;
        req1  = 1'b1;
        step("reset_mid_g1");
        step("reset_mid_xfer");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (grant1 !== 1'b0 || valid !== 1'b0 || s !== '0 || grant0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got g0=%b g1=%b valid=%b s=%h, expected all zero",
                     grant0, grant1, valid, s);
        end
        req0 = 1'b1;
        req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step("reset_mid_restart");
        n_tests++;
        if (grant0 !== 1'b1 || grant1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got g0=%b g1=%b, expected g0=1 g1=0", grant0, grant1);
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 3) != 0);
            data0 = 4'($urandom_range(0, 15));
            data1 = 4'($urandom_range(0, 15));
            step("random");
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_handover();
        test_hold_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, 4, bit width of each data input and of the shared mux output.
REQ-002 Parameter MAX_HOLD, 4, maximum consecutive grant cycles while the other requester waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  requester 0 wants the shared mux.
REQ-006 req1  input  1  requester 1 wants the shared mux.
REQ-007 data0  input  WIDTH  requester 0 data, mux input a.
REQ-008 data1  input  WIDTH  requester 1 data, mux input b.
REQ-009 grant0  output  1  requester 0 owns the mux this cycle.
REQ-010 grant1  output  1  requester 1 owns the mux this cycle.
REQ-011 select  output  1  shared mux select; 0 = data0, 1 = data1.
REQ-012 s  output  WIDTH  registered shared mux output.
REQ-013 valid  output  1  s holds data transferred for a live grant.

Function
REQ-014 FSM states IDLE, GRANT0, GRANT1; grant0 = (state==GRANT0), grant1 = (state==GRANT1), decoded from registered state only.
REQ-015 select = 1 in GRANT1, 0 otherwise.
REQ-016 grant0 and grant1 never both high.
REQ-017 IDLE: req0 only -> GRANT0; req1 only -> GRANT1; both -> the requester not equal to last-served pointer; none -> stay IDLE.
REQ-018 Grant latency: req sampled high at edge k in IDLE -> grant high after edge k.
REQ-019 Each edge in GRANTn with reqn high: s <= selected data (data0 if select=0, else data1), valid <= 1; hold_cnt increments.
REQ-020 Each edge in GRANTn with reqn low: valid <= 0, s holds value, no transfer counted.
REQ-021 Data latency: data present on the granted input at edge k appears on s after edge k, one cycle after grant rises.
REQ-022 Leave GRANTn when reqn low: other req high -> GRANT(other), else IDLE; last-served <= n; hold_cnt <= 0.
REQ-023 Leave GRANTn when hold_cnt == MAX_HOLD-1 at the edge and other req high -> GRANT(other); last-served <= n; hold_cnt <= 0.
REQ-024 Other req low at hold limit -> stay GRANTn; hold_cnt saturates at MAX_HOLD-1.
REQ-025 hold_cnt width 4 bits; no wrap-around.
REQ-026 Requester dropping and the other rising on the same edge -> direct GRANTn -> GRANT(other), no IDLE cycle.

Reset
REQ-027 reset high forces, asynchronously: state IDLE, grant0=0, grant1=0, select=0, s=0, valid=0, hold_cnt=0, last-served=1 (first tie goes to requester 0).
REQ-028 reset asserted mid-grant drops grants and valid immediately; in-flight data lost; arbitration restarts from IDLE on first edge after release.

Configuration
REQ-029 Macro MUX_ARBITER_HOLD_EN defined: hold behaviour per REQ-023/REQ-024 using MAX_HOLD.
REQ-030 Macro MUX_ARBITER_HOLD_EN undefined: MAX_HOLD ignored, behaves as MAX_HOLD=1; re-arbitrate every cycle, alternating each cycle while both requesters are high.

Verification
REQ-031 Reset mid-operation: reset pulse while GRANT1 with valid=1 -> grant1, valid, s drop to 0 without clock edge; req0=req1=1 after release -> GRANT0 first.
REQ-032 Single requester: req0=1 from edge 1, data0=4'b1101 -> grant0=1 after edge 1; s=4'b1101, valid=1 after edge 2; req0=0 -> IDLE next edge, valid=0.
REQ-033 Contention with HOLD_EN, MAX_HOLD=4, both req high from reset release -> grant0 for 4 cycles, grant1 for 4 cycles, repeating; select toggles with grant1.
REQ-034 Contention without HOLD_EN, both req high -> grant0/grant1 alternate every cycle; s alternates data0=4'b0001, data1=4'b0010.
REQ-035 Handover: req0 drops while req1 rises on same edge in GRANT0 -> GRANT1 next cycle, no IDLE, never both grants high.
REQ-036 Hold saturation: req1 alone for 20 cycles, MAX_HOLD=4 -> grant1 continuous; req0 rises -> grant moves to 0 on next edge.
